// File: rtl/a2d_resp_if.sv
// a2d_resp_if: SPI pin bundle between the slider initiator (master) and the A2D responder (slave).
`default_nettype none

interface a2d_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

`default_nettype wire

// File: rtl/a2d_resp.sv
// ============================================================================
// a2d_resp : SPI mode-3 responder emulating an 8-channel 12-bit A2D converter.
//            Optional macro A2D_MISO_TRI_EN tri-states MISO when not selected.
// Revision : 1.0
// ============================================================================
`default_nettype none

module a2d_resp #(
    parameter int NUM_CH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    a2d_resp_if.slave                 spi,
    input  wire logic [12*NUM_CH-1:0] SAMPLES,
    output logic                      cmd_vld,
    output logic [2:0]                cmd_ch,
    output logic                      frm_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_ss_sync;
    logic [2:0]   r_sclk_sync;
    logic [1:0]   r_mosi_sync;
    logic         r_armed;
    logic [15:0]  r_tx;
    logic [15:0]  r_rx;
    logic [4:0]   r_bit_cnt;
    logic         r_first;
    logic [11:0]  r_resp;
    logic [2:0]   r_cmd_ch;
    logic         r_cmd_vld;
    logic         r_frm_err;
    logic         w_enter;
    logic         w_accept;
    logic         w_reject;
    logic [11:0]  w_sample;
    logic         w_unused;

    wire logic w_ss_fall   = ~r_ss_sync[1]   &  r_ss_sync[2];
    wire logic w_ss_rise   =  r_ss_sync[1]   & ~r_ss_sync[2];
    wire logic w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
    wire logic w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];

    assign w_unused = r_rx[15];

    always_comb begin
        w_sample = 12'h000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_rx[13:11] == k[2:0]) w_sample = SAMPLES[12*k +: 12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_enter  = 1'b0;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE:  if (w_ss_fall && r_armed) begin
                         w_next  = S_SHIFT;
                         w_enter = 1'b1;
                     end
            S_SHIFT: if (w_ss_rise) w_next = S_DONE;
            S_DONE:  begin
                         w_next = S_IDLE;
                         if (r_bit_cnt == 5'd16) w_accept = 1'b1;
                         else                    w_reject = 1'b1;
                     end
            default: w_next = S_IDLE;
        endcase
    end

    // SS_n syncs reset low so a select held across reset cannot arm the responder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync   <= 3'b000;
            r_sclk_sync <= 3'b111;
            r_mosi_sync <= 2'b00;
            r_armed     <= 1'b0;
            r_tx        <= 16'h0000;
            r_rx        <= 16'h0000;
            r_bit_cnt   <= 5'd0;
            r_first     <= 1'b0;
            r_resp      <= 12'h000;
            r_cmd_ch    <= 3'd0;
            r_cmd_vld   <= 1'b0;
            r_frm_err   <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], spi.SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], spi.SCLK};
            r_mosi_sync <= {r_mosi_sync[0], spi.MOSI};
            if (r_ss_sync[1]) r_armed <= 1'b1;
            r_cmd_vld <= w_accept;
            r_frm_err <= w_reject;
            if (w_enter) begin
                r_tx      <= {4'h0, r_resp};
                r_bit_cnt <= 5'd0;
                r_first   <= 1'b1;
            end else if (r_state == S_SHIFT) begin
                if (w_sclk_rise) begin
                    r_rx <= {r_rx[14:0], r_mosi_sync[1]};
                    if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                // MSB is already on MISO at entry, so the first fall must not shift
                if (w_sclk_fall) begin
                    if (r_first) r_first <= 1'b0;
                    else         r_tx    <= {r_tx[14:0], 1'b0};
                end
            end
            if (w_accept) begin
                r_cmd_ch <= r_rx[13:11];
                r_resp   <= w_sample;
            end
        end
    end

`ifdef A2D_MISO_TRI_EN
    assign spi.MISO = (r_ss_sync[1] || r_state == S_IDLE) ? 1'bz : r_tx[15];
`else
    assign spi.MISO = (r_state == S_SHIFT) ? r_tx[15] : 1'b0;
`endif

    assign cmd_vld = r_cmd_vld;
    assign cmd_ch  = r_cmd_ch;
    assign frm_err = r_frm_err;

endmodule

`default_nettype wire

// File: tb/tb_a2d_resp.sv
// tb_a2d_resp: randomized SPI transactions against a transaction-level model, for NUM_CH=8 and NUM_CH=6.
`default_nettype none

module tb_a2d_resp;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss = 1'b1;
    logic        sclk = 1'b1;
    logic        mosi = 1'b0;
    logic [95:0] samples = '0;
    logic        cmd_vld8, frm_err8, cmd_vld6, frm_err6;
    logic [2:0]  cmd_ch8, cmd_ch6;

    a2d_resp_if spi8 ();
    a2d_resp_if spi6 ();
    assign spi8.SS_n = ss;
    assign spi8.SCLK = sclk;
    assign spi8.MOSI = mosi;
    assign spi6.SS_n = ss;
    assign spi6.SCLK = sclk;
    assign spi6.MOSI = mosi;

    a2d_resp #(.NUM_CH(8)) dut8 (.clk(clk), .rst_n(rst_n), .spi(spi8), .SAMPLES(samples),
                                 .cmd_vld(cmd_vld8), .cmd_ch(cmd_ch8), .frm_err(frm_err8));
    a2d_resp #(.NUM_CH(6)) dut6 (.clk(clk), .rst_n(rst_n), .spi(spi6), .SAMPLES(samples[71:0]),
                                 .cmd_vld(cmd_vld6), .cmd_ch(cmd_ch6), .frm_err(frm_err6));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // transaction-level model state
    logic [11:0] m_resp8 = 12'h000, m_resp6 = 12'h000;
    logic [2:0]  m_ch8 = 3'd0, m_ch6 = 3'd0;
    bit          in_win = 1'b0;
    bit          idle_chk = 1'b0;
    int          v8, e8, v6, e6;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (in_win) begin
            v8 += int'(cmd_vld8);
            e8 += int'(frm_err8);
            v6 += int'(cmd_vld6);
            e6 += int'(frm_err6);
        end else if (rst_n) begin
            chk("quiet8", {27'd0, cmd_vld8, frm_err8, cmd_ch8}, {27'd0, 2'b00, m_ch8});
            chk("quiet6", {27'd0, cmd_vld6, frm_err6, cmd_ch6}, {27'd0, 2'b00, m_ch6});
            if (idle_chk) begin
`ifdef A2D_MISO_TRI_EN
                chk("miso_idle8", {31'd0, spi8.MISO}, {31'd0, 1'bz});
`else
                chk("miso_idle8", {31'd0, spi8.MISO}, 32'd0);
`endif
            end
        end
    end

    function automatic logic [11:0] pick(input logic [95:0] s, input int ch, input int nch);
        if (ch >= nch) return 12'h000;
        return s[12*ch +: 12];
    endfunction

    task automatic xfer(input logic [15:0] cmd, input int nbits, input bit chg, input logic [95:0] mid,
                        output logic [31:0] got8, output logic [31:0] got6);
        logic [31:0] x8, x6;
        logic [95:0] snap;
        int ch;
        x8 = {4'h0, m_resp8, 16'h0000} >> (32 - nbits);
        x6 = {4'h0, m_resp6, 16'h0000} >> (32 - nbits);
        got8 = '0;
        got6 = '0;
        @(posedge clk); #1;
        idle_chk = 1'b0;
        ss = 1'b0;
        repeat (HALF) @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = (i < 16) ? cmd[15-i] : 1'b0;
            if (chg && i == 8) samples = mid;
            repeat (HALF) @(posedge clk); #1;
            got8 = {got8[30:0], spi8.MISO};
            got6 = {got6[30:0], spi6.MISO};
            sclk = 1'b1;
            repeat (HALF) @(posedge clk); #1;
        end
        snap = samples;
        v8 = 0; e8 = 0; v6 = 0; e6 = 0;
        in_win = 1'b1;
        ss = 1'b1;
        repeat (9) @(posedge clk); #1;
        chk("reply8", got8, x8);
        chk("reply6", got6, x6);
        if (nbits == 16) begin
            ch = int'(cmd[13:11]);
            m_ch8 = cmd[13:11];
            m_ch6 = cmd[13:11];
            m_resp8 = pick(snap, ch, 8);
            m_resp6 = pick(snap, ch, 6);
        end
        chk("pulses8", {v8[15:0], e8[15:0]}, (nbits == 16) ? 32'h0001_0000 : 32'h0000_0001);
        chk("pulses6", {v6[15:0], e6[15:0]}, (nbits == 16) ? 32'h0001_0000 : 32'h0000_0001);
        chk("cmd_ch8", {29'd0, cmd_ch8}, {29'd0, m_ch8});
        chk("cmd_ch6", {29'd0, cmd_ch6}, {29'd0, m_ch6});
        in_win = 1'b0;
        idle_chk = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g8, g6;
        logic [95:0] rs;
        rs = {$urandom, $urandom, $urandom};
        rs[47:36] = 12'hA5C;
        samples = rs;
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("rst_state8", {28'd0, cmd_vld8, frm_err8, cmd_ch8[1:0]}, 32'd0);
        chk("rst_ch8", {29'd0, cmd_ch8}, 32'd0);
        chk("rst_state6", {28'd0, cmd_vld6, frm_err6, cmd_ch6[1:0]}, 32'd0);
`ifdef A2D_MISO_TRI_EN
        chk("rst_miso", {31'd0, spi8.MISO}, {31'd0, 1'bz});
`else
        chk("rst_miso", {31'd0, spi8.MISO}, 32'd0);
`endif
        idle_chk = 1'b1;

        // ch3 command, then read it back
        xfer(16'h1800, 16, 1'b0, '0, g8, g6);
        chk("first_reply", g8, 32'h0000_0000);
        chk("first_ch", {29'd0, cmd_ch8}, 32'd3);
        xfer(16'($urandom), 16, 1'b0, '0, g8, g6);
        chk("ch3_reply", g8, 32'h0000_0A5C);

        // channel sweep with fresh samples each frame
        for (int c = 0; c < 8; c++) begin
            samples = {$urandom, $urandom, $urandom};
            xfer({2'($urandom), 3'(c), 11'($urandom)}, 16, 1'b0, '0, g8, g6);
        end

        // samples change mid-frame
        xfer({2'b00, 3'd5, 11'h000}, 16, 1'b1, {$urandom, $urandom, $urandom}, g8, g6);
        xfer({2'b00, 3'd5, 11'h000}, 16, 1'b1, {$urandom, $urandom, $urandom}, g8, g6);

        // short frame aborted after 9 clocks
        xfer(16'($urandom), 9, 1'b0, '0, g8, g6);
        xfer(16'($urandom), 16, 1'b0, '0, g8, g6);

        // ch7 beyond NUM_CH=6
        xfer({2'b11, 3'd7, 11'h7FF}, 16, 1'b0, '0, g8, g6);
        chk("ch7_cmd6", {29'd0, cmd_ch6}, 32'd7);
        xfer(16'h0000, 16, 1'b0, '0, g8, g6);
        chk("ch7_reply6", g6, 32'h0000_0000);

        // reset in the middle of a frame
        @(posedge clk); #1;
        idle_chk = 1'b0;
        ss = 1'b0;
        repeat (HALF) @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0; mosi = 1'($urandom);
            repeat (HALF) @(posedge clk); #1;
            sclk = 1'b1;
            repeat (HALF) @(posedge clk); #1;
        end
        rst_n = 1'b0;
        m_resp8 = 12'h000; m_resp6 = 12'h000; m_ch8 = 3'd0; m_ch6 = 3'd0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b0;
            repeat (HALF) @(posedge clk); #1;
            sclk = 1'b1;
            repeat (HALF) @(posedge clk); #1;
        end
        ss = 1'b1;
        repeat (10) @(posedge clk); #1;
        idle_chk = 1'b1;
        samples = {$urandom, $urandom, $urandom};
        xfer({2'b00, 3'd2, 11'h000}, 16, 1'b0, '0, g8, g6);
        chk("post_rst_reply", g8, 32'h0000_0000);
        chk("post_rst_ch", {29'd0, cmd_ch8}, 32'd2);
        xfer(16'($urandom), 16, 1'b0, '0, g8, g6);

        // random mix of full and malformed frames
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 3) == 0) samples = {$urandom, $urandom, $urandom};
            xfer(16'($urandom), ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(0, 20)),
                 1'b0, '0, g8, g6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/a2d_resp.md
# a2d_resp

Synthesizable SPI responder that emulates the 8-channel, 12-bit A2D converter read by the slider interface. Receives 16-bit channel-select commands on MOSI and returns on MISO, during the following transaction, the 12-bit sample of the channel selected by the previous command. Sits opposite the slider SPI initiator; used on FPGA builds in place of the external converter and as a synthesizable bench partner.

## Interface
- NUM_CH, 8: channels implemented (1..8); channel index >= NUM_CH reads 12'h000.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  SPI select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock from initiator, idles high, asynchronous to clk.
- MOSI  in  1  command data from initiator.
- MISO  out  1  response data to initiator.
- SAMPLES  in  12*NUM_CH  channel samples, channel k at bits [12k+11:12k].
- cmd_vld  out  1  one-clk pulse: valid command accepted.
- cmd_ch  out  3  channel of last accepted command.
- frm_err  out  1  one-clk pulse: transaction closed with bit count != 16.

## Operation
- SS_n, SCLK, MOSI each pass a 2-flop synchronizer; third flop on SCLK/SS_n gives edge detect (sclk_rise, sclk_fall, ss_fall, ss_rise).
- SPI mode 3, MSB first: initiator changes MOSI after SCLK fall, samples MISO on SCLK rise.
- States IDLE, SHIFT, DONE.
- IDLE -> SHIFT on ss_fall, only if armed (SS_n seen high at least 1 clk since reset). On entry: tx_shft <= {4'h0, resp}; bit_cnt <= 0; first <= 1.
- SHIFT: sclk_rise -> rx_shft <= {rx_shft[14:0], MOSI_sync}, bit_cnt++ (saturates at 31). sclk_fall -> if first, clear first (no shift); else tx_shft <= {tx_shft[14:0], 1'b0}. MISO = tx_shft[15].
- SHIFT -> DONE on ss_rise. DONE lasts 1 clk then IDLE.
- DONE, bit_cnt == 16: cmd_ch <= rx_shft[13:11]; resp <= SAMPLES slice for that channel (12'h000 if >= NUM_CH), snapshotted now, stable through next transaction; cmd_vld = 1. rx_shft[15:14] and [10:0] ignored.
- DONE, bit_cnt != 16: frm_err = 1; cmd_ch and resp unchanged.
- Reset values: MISO 0, cmd_ch 3'd0, resp 12'h000, cmd_vld 0, frm_err 0, state IDLE, armed 0, bit_cnt 0.

## Timing
- Synchronizer + edge detect: edge acted on 3 clk after pin change.
- Requirements on initiator: SCLK high and low phases >= 4 clk; SS_n fall to first SCLK fall >= 4 clk; last SCLK rise to SS_n rise >= 4 clk; SS_n high >= 4 clk between transactions.
- MISO valid <= 4 clk after ss_fall and after each SCLK fall; stable across the next SCLK rise given the above.
- cmd_vld/frm_err assert 4 clk after SS_n pin rise (DONE cycle); resp for the next transaction ready same cycle.
- Same-cycle sclk_rise and ss_rise: bit is captured first, then close evaluated with updated count.
- Reset mid-transaction: all state cleared; rest of that transaction ignored (armed 0) until SS_n returns high; no cmd_vld/frm_err for it.
- First transaction after reset returns 16'h0000.

## Configuration
- A2D_MISO_TRI_EN defined: MISO = 1'bz whenever synchronized SS_n is high or state is IDLE (shared-bus use).
- Undefined: MISO driven 0 outside SHIFT; all other behaviour identical.

## Test plan
- Reset then command ch 3 (16'h1800), SAMPLES ch3 = 12'hA5C: first reply 16'h0000, cmd_vld pulse, cmd_ch 3; second transaction (any cmd) returns 16'h0A5C.
- Sweep ch 0..7 back-to-back with random samples: each reply equals previous command's channel sample, upper 4 bits 0.
- SAMPLES change during a transaction: reply equals value snapshotted at prior ss_rise, not new value.
- Abort after 9 SCLK cycles: frm_err pulse, no cmd_vld, cmd_ch and next reply unchanged.
- NUM_CH=6, command ch 7: cmd_ch 7, next reply 16'h0000.
- rst_n pulsed after bit 5 then SS_n rises and a full ch 2 command follows: no pulses for aborted frame; ch 2 command accepted normally; with A2D_MISO_TRI_EN, MISO reads z while SS_n high.
